// File: rtl/vector_sync_pkg.sv
// Shared types and helpers for the vector_sync_qualifier destination-domain qualifier.
package vector_sync_pkg;

  typedef enum logic {ST_STABLE, ST_SETTLING} qual_state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int clog2_cnt(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_sync_qualifier.sv
// Publishes a synchronised vector only after it has held identical for pSTABLE_CYCLES samples.
// Optional rejected-candidate counter enabled by defining VECTOR_SYNC_GLITCH_CNT_EN.
module vector_sync_qualifier
  import vector_sync_pkg::*;
#(
  parameter int                pWIDTH         = 18,
  parameter int                pSTABLE_CYCLES = 3,
  parameter logic [pWIDTH-1:0] pRESET_VALUE   = '0,
  parameter int                pGLITCH_W      = 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [pWIDTH-1:0]    ivector,
  output logic [pWIDTH-1:0]    ovector,
  output logic                 ochange,
  output logic                 osettling,
  input  logic                 iclr_glitch,
  output logic [pGLITCH_W-1:0] oglitch_cnt
);

  localparam int            CW       = clog2_cnt(pSTABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(pSTABLE_CYCLES - 1);

  if (pSTABLE_CYCLES < 1) begin : g_bad_stable
    $error("vector_sync_qualifier: pSTABLE_CYCLES must be >= 1");
  end
  if (pWIDTH < 1) begin : g_bad_width
    $error("vector_sync_qualifier: pWIDTH must be >= 1");
  end

  qual_state_e       state_q, state_d;
  logic [pWIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [pWIDTH-1:0] ovector_d;
  logic              change_d;
  logic              glitch_ev;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      ovector <= pRESET_VALUE;
      ochange <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      ovector <= ovector_d;
      ochange <= change_d;
    end
  end

  // cand always equals the previous sample while SETTLING, so cnt is the run length.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    ovector_d = ovector;
    change_d  = 1'b0;
    glitch_ev = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (ivector != ovector) begin
          if (pSTABLE_CYCLES == 1) begin
            ovector_d = ivector;
            change_d  = 1'b1;
          end else begin
            cand_d  = ivector;
            cnt_d   = CW'(1);
            state_d = ST_SETTLING;
          end
        end
      end
      ST_SETTLING: begin
        if (ivector == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            ovector_d = cand_q;
            change_d  = 1'b1;
            state_d   = ST_STABLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (ivector == ovector) begin
          state_d   = ST_STABLE;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end else begin
          cand_d    = ivector;
          cnt_d     = CW'(1);
          glitch_ev = 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign osettling = (state_q == ST_SETTLING);

`ifdef VECTOR_SYNC_GLITCH_CNT_EN
  logic [pGLITCH_W-1:0] glitch_q;

  // Clear wins over a same-cycle glitch event.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (iclr_glitch) begin
      glitch_q <= '0;
    end else if (glitch_ev && (glitch_q != '1)) begin
      glitch_q <= glitch_q + pGLITCH_W'(1);
    end
  end

  assign oglitch_cnt = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = iclr_glitch ^ glitch_ev;
  assign oglitch_cnt   = '0;
`endif

endmodule

// File: tb/tb_vector_sync_qualifier.sv
// Directed bench for vector_sync_qualifier: a 3-cycle and a 1-cycle instance share one input.
module tb_vector_sync_qualifier;

  localparam int W  = 8;
  localparam int GW = 8;
  localparam int GMAX = (1 << GW) - 1;
`ifdef VECTOR_SYNC_GLITCH_CNT_EN
  localparam bit GL_EN = 1'b1;
`else
  localparam bit GL_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          iclr_glitch = 1'b0;
  logic [W-1:0]  ivector = 8'hFF;

  logic [W-1:0]  ov3, ov1;
  logic          chg3, chg1, set3, set1;
  logic [GW-1:0] gl3, gl1;

  // clock / reset
  always #5 clock = ~clock;

  vector_sync_qualifier #(
    .pWIDTH(W), .pSTABLE_CYCLES(3), .pRESET_VALUE(8'h00), .pGLITCH_W(GW)
  ) dut (
    .clock(clock), .rst_n(rst_n), .ivector(ivector), .ovector(ov3),
    .ochange(chg3), .osettling(set3), .iclr_glitch(iclr_glitch), .oglitch_cnt(gl3)
  );

  vector_sync_qualifier #(
    .pWIDTH(W), .pSTABLE_CYCLES(1), .pRESET_VALUE(8'h00), .pGLITCH_W(GW)
  ) dut1 (
    .clock(clock), .rst_n(rst_n), .ivector(ivector), .ovector(ov1),
    .ochange(chg1), .osettling(set1), .iclr_glitch(iclr_glitch), .oglitch_cnt(gl1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nst(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Model: publish once the most recent run of identical samples reaches the required
  // length and differs from the published value; a broken pending run is a glitch.
  logic [W-1:0] m_ov[2], m_prev[2];
  bit           m_have[2], m_chg[2], m_set[2];
  int           m_run[2], m_gl[2];
  bit           pending, glitch;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ov[k] = '0; m_prev[k] = '0; m_have[k] = 0;
        m_chg[k] = 0; m_set[k] = 0; m_run[k] = 0; m_gl[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pending = m_have[k] && (m_prev[k] != m_ov[k]);
        glitch  = pending && (ivector != m_prev[k]);
        if (ivector != m_ov[k])
          m_run[k] = (m_have[k] && ivector == m_prev[k]) ? m_run[k] + 1 : 1;
        else
          m_run[k] = 0;
        m_chg[k] = (ivector != m_ov[k]) && (m_run[k] >= nst(k));
        if (m_chg[k]) begin
          m_ov[k]  = ivector;
          m_run[k] = 0;
        end
        m_set[k] = (ivector != m_ov[k]);
        if (GL_EN) begin
          if (iclr_glitch) m_gl[k] = 0;
          else if (glitch && m_gl[k] < GMAX) m_gl[k] = m_gl[k] + 1;
        end
        m_prev[k] = ivector;
        m_have[k] = 1;
      end
    end
  end

  // scoreboard compare, every cycle on the inactive edge
  always @(negedge clock) begin
    check("ov3",  ov3,  m_ov[0]);
    check("chg3", chg3, m_chg[0]);
    check("set3", set3, m_set[0]);
    check("gl3",  gl3,  m_gl[0]);
    check("ov1",  ov1,  m_ov[1]);
    check("chg1", chg1, m_chg[1]);
    check("set1", set1, m_set[1]);
    check("gl1",  gl1,  m_gl[1]);
  end

  // driver
  task automatic drive(input logic [W-1:0] v, input int n);
    ivector = v;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // 1: reset with input all ones
    repeat (2) @(negedge clock);
    check("rst_ov",  ov3,  8'h00);
    check("rst_chg", chg3, 1'b0);
    check("rst_set", set3, 1'b0);
    check("rst_gl",  gl3,  8'h00);
    ivector = 8'h00;
    @(negedge clock);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // 2: 00 -> 2A held
    drive(8'h2A, 1);
    check("t2_set_e1", set3, 1'b1);
    check("t2_ov_e1",  ov3,  8'h00);
    check("t2_n1_ov",  ov1,  8'h2A);
    check("t2_n1_chg", chg1, 1'b1);
    @(negedge clock);
    check("t2_set_e2", set3, 1'b1);
    check("t2_chg_e2", chg3, 1'b0);
    @(negedge clock);
    check("t2_ov_e3",  ov3,  8'h2A);
    check("t2_chg_e3", chg3, 1'b1);
    check("t2_set_e3", set3, 1'b0);
    @(negedge clock);
    check("t2_chg_e4", chg3, 1'b0);
    check("t2_n1_chg_e4", chg1, 1'b0);

    // 3: two-cycle excursion to 15 and back
    drive(8'h15, 2);
    drive(8'h2A, 1);
    check("t3_ov",  ov3,  8'h2A);
    check("t3_chg", chg3, 1'b0);
    check("t3_gl",  gl3,  GL_EN ? 32'd1 : 32'd0);
    drive(8'h2A, 2);

    // 4: one-cycle 01, then 02 held
    drive(8'h01, 1);
    drive(8'h02, 2);
    check("t4_ov_hold", ov3, 8'h2A);
    @(negedge clock);
    check("t4_ov",  ov3,  8'h02);
    check("t4_chg", chg3, 1'b1);
    check("t4_gl",  gl3,  GL_EN ? 32'd2 : 32'd0);
    drive(8'h02, 2);

    // 5: reset mid-settling with cnt=2
    drive(8'h55, 2);
    check("t5_set_pre", set3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ov",  ov3,  8'h00);
    check("t5_rst_chg", chg3, 1'b0);
    check("t5_rst_set", set3, 1'b0);
    check("t5_rst_gl",  gl3,  8'h00);
    @(negedge clock);
    #2 rst_n = 1'b1;
    @(negedge clock);
    check("t5_ov_e1", ov3, 8'h00);
    @(negedge clock);
    check("t5_ov_e2", ov3, 8'h00);
    @(negedge clock);
    check("t5_ov_e3",  ov3,  8'h55);
    check("t5_chg_e3", chg3, 1'b1);

    // 6: 300 glitches saturate the counter, then clear beats a same-cycle glitch
    for (int i = 0; i <= 300; i++) drive((i % 2) ? 8'h02 : 8'h01, 1);
    check("t6_sat",    gl3, GL_EN ? 32'hFF : 32'd0);
    check("t6_ov",     ov3, 8'h55);
    check("t6_n1_gl",  gl1, 8'h00);
    iclr_glitch = 1'b1;
    drive(8'h02, 1);
    iclr_glitch = 1'b0;
    check("t6_clr",    gl3, 8'h00);
    drive(8'h55, 1);
    check("t6_after",  gl3, GL_EN ? 32'd1 : 32'd0);

    // 7: single-cycle instance follows every change
    drive(8'hAA, 1);
    check("t7_n1_ov",  ov1,  8'hAA);
    check("t7_n1_chg", chg1, 1'b1);
    check("t7_n1_set", set1, 1'b0);
    drive(8'h0F, 1);
    check("t7_n1_ov2", ov1,  8'h0F);
    check("t7_n1_chg2", chg1, 1'b1);
    drive(8'h0F, 4);
    check("t7_ov3", ov3, 8'h0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
